// File: rtl/rect_cyl_isqrt_if.sv
// Handshake bundle for the sequential integer square-root stage.
// The slave side is the root stage; the master side is its driver/consumer.
interface rect_cyl_isqrt_if #(
    parameter int IN_W = 16
);
    localparam int OUT_W = IN_W / 2;

    logic             ena;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_root;
    logic [OUT_W:0]   out_rem;

    modport slave (
        input  ena, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root, out_rem
    );

    modport master (
        output ena, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root, out_rem
    );
endinterface

// File: rtl/rect_cyl_isqrt.sv
// Restoring digit-by-digit integer square root, one root bit per cycle.
// Returns floor(sqrt(in_data)) and in_data - root^2 through valid/ready.
//
// state | meaning
// IDLE  | waiting for a radicand; in_ready follows ena
// CALC  | retiring one root bit per enabled cycle
// DONE  | result presented; waits for out_ready
module rect_cyl_isqrt #(
    parameter int IN_W = 16
) (
    input logic             clk,
    input logic             rst,
    rect_cyl_isqrt_if.slave bus
);
    localparam int OUT_W = IN_W / 2;
    localparam int RW    = OUT_W + 2;
    localparam int SW    = OUT_W + 4;
    localparam int OW1   = OUT_W + 1;
    localparam int CW    = (OUT_W > 2) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  rad_q, rad_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [OUT_W-1:0] root_q, root_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_root_q, out_root_d;
    logic [OW1-1:0]   out_rem_q, out_rem_d;

    logic [SW-1:0]    rem_sh;
    logic [SW-1:0]    trial;
    logic             ge;
    logic [RW-1:0]    rem_nx;
    logic [OUT_W-1:0] root_nx;

    // Single iteration; the widened compare keeps the shifted remainder exact.
    always_comb begin
        rem_sh  = {rem_q, rad_q[IN_W-1:IN_W-2]};
        trial   = {2'b00, root_q, 2'b01};
        ge      = (rem_sh >= trial);
        rem_nx  = RW'(ge ? (rem_sh - trial) : rem_sh);
        root_nx = OUT_W'({root_q, ge});
    end

    always_comb begin
        state_d    = state_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        cnt_d      = cnt_q;
        out_root_d = out_root_q;
        out_rem_d  = out_rem_q;
        if (bus.ena) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_d = CALC;
                        rad_d   = bus.in_data;
                        rem_d   = '0;
                        root_d  = '0;
                        cnt_d   = CW'(OUT_W - 1);
                    end
                end
                CALC: begin
                    rad_d  = {rad_q[IN_W-3:0], 2'b00};
                    rem_d  = rem_nx;
                    root_d = root_nx;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d    = DONE;
                        out_root_d = root_nx;
                        out_rem_d  = OW1'(rem_nx);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            out_root_q <= '0;
            out_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            cnt_q      <= cnt_d;
            out_root_q <= out_root_d;
            out_rem_q  <= out_rem_d;
        end
    end

    assign bus.in_ready  = bus.ena & (state_q == IDLE);
    assign bus.out_valid = bus.ena & (state_q == DONE);
    assign bus.out_root  = out_root_q;
    assign bus.out_rem   = out_rem_q;
endmodule

// File: tb/tb_rect_cyl_isqrt.sv
// Directed bench for rect_cyl_isqrt with a cycle-level behavioural model
// checked on every falling edge, plus literal expectations per test.
module tb_rect_cyl_isqrt;
    localparam int IN_W = 16;
    localparam int OUT_W = IN_W / 2;
    localparam int LAT = OUT_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rect_cyl_isqrt_if #(.IN_W(IN_W)) bus ();
    rect_cyl_isqrt #(.IN_W(IN_W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;

    bit m_busy = 1'b0;
    int m_edges = 0;
    int m_x = 0;
    int m_root = 0;
    int m_rem = 0;

    function automatic int isqrt_f(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: in flight for LAT enabled edges after accept, then holds until out_ready.
    task automatic model_step();
        if (rst) begin
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_out_root", int'(bus.out_root), 0);
            check("rst_out_rem", int'(bus.out_rem), 0);
            check("rst_in_ready", int'(bus.in_ready), int'(bus.ena));
            m_busy = 1'b0; m_edges = 0; m_root = 0; m_rem = 0;
        end else begin
            check("m_in_ready", int'(bus.in_ready), int'(bus.ena && !m_busy));
            check("m_out_valid", int'(bus.out_valid), int'(bus.ena && m_busy && m_edges == LAT));
            check("m_out_root", int'(bus.out_root), m_root);
            check("m_out_rem", int'(bus.out_rem), m_rem);
            if (bus.ena) begin
                if (!m_busy) begin
                    if (bus.in_valid) begin
                        m_busy = 1'b1; m_edges = 0; m_x = int'(bus.in_data);
                    end
                end else if (m_edges < LAT) begin
                    m_edges++;
                    if (m_edges == LAT) begin
                        m_root = isqrt_f(m_x);
                        m_rem = m_x - m_root * m_root;
                    end
                end else if (bus.out_ready) begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input int x, input int er, input int erem,
                           input int elat, input int lo_at, input int lo_n);
        int n;
        bit got;
        n = 0;
        while (!bus.in_ready && n < 30) begin tick(); n++; end
        check({name, "_ready"}, int'(bus.in_ready), 1);
        bus.in_data = 16'(x);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data = 16'hA5A5;
        n = 0; got = 1'b0;
        while (!got && n < 60) begin
            bus.ena = !(n >= lo_at && n < lo_at + lo_n);
            tick();
            n++;
            got = bus.out_valid;
        end
        bus.ena = 1'b1;
        check({name, "_latency"}, n, elat);
        check({name, "_root"}, int'(bus.out_root), er);
        check({name, "_rem"}, int'(bus.out_rem), erem);
        check({name, "_model_root"}, isqrt_f(x), er);
        check({name, "_model_rem"}, x - isqrt_f(x) * isqrt_f(x), erem);
    endtask

    initial begin
        int prev, c, n, step;
        bit ok;
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        run_one("r25", 25, 5, 0, 8, 1000, 0);
        tick();
        check("r25_post_in_ready", int'(bus.in_ready), 1);
        check("r25_post_out_valid", int'(bus.out_valid), 0);

        run_one("r0", 0, 0, 0, 8, 1000, 0);          tick();
        run_one("r65535", 65535, 255, 510, 8, 1000, 0); tick();
        run_one("r24", 24, 4, 8, 8, 1000, 0);        tick();
        run_one("r200", 200, 14, 4, 8, 1000, 0);     tick();

        // Backpressure: result must hold and new requests must be refused.
        bus.out_ready = 1'b0;
        run_one("bp", 3000, 54, 84, 8, 1000, 0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data = 16'd7;
            tick();
            check("bp_root_hold", int'(bus.out_root), 54);
            check("bp_rem_hold", int'(bus.out_rem), 84);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", int'(bus.out_valid), 0);
        check("bp_release_in_ready", int'(bus.in_ready), 1);
        tick();
        check("bp_single_transfer", int'(bus.out_valid), 0);

        run_one("ena", 144, 12, 0, 11, 2, 3);
        tick();

        // Reset in the 4th CALC cycle clears outputs without waiting for a clock.
        bus.in_data = 16'd1000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_root", int'(bus.out_root), 0);
        check("async_rst_rem", int'(bus.out_rem), 0);
        tick();
        rst = 1'b0;
        tick();
        run_one("after_rst", 81, 9, 0, 8, 1000, 0);
        tick();

        // Back-to-back sweep: edges of the range densely, the middle strided.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        prev = -1; c = 0;
        for (int v = 0; v < 65536; v += step) begin
            step = (v < 300 || v > 65279) ? 1 : 41;
            bus.in_data = 16'(v);
            n = 0;
            do begin
                ok = bus.in_ready;
                tick();
                c++; n++;
            end while (!ok && n < 40);
            if (!ok) check("sweep_accept_timeout", 0, 1);
            if (prev >= 0) check("sweep_ii", c - prev, OUT_W + 2);
            prev = c;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
